// File: rtl/ps2_pkg.sv
// ps2_pkg: shared definitions for the PS/2 key tracker.
//   PS2_BREAK / PS2_EXT : prefix bytes the code decoder reacts to.
//   frame_state_e       : serial frame receiver state encoding.
//   pack_code()         : forms the 9-bit {extended, scan code} table key.
package ps2_pkg;

    localparam logic [7:0] PS2_BREAK = 8'hF0;
    localparam logic [7:0] PS2_EXT   = 8'hE0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } frame_state_e;

    function automatic logic [8:0] pack_code(input logic ext, input logic [7:0] code);
        return {ext, code};
    endfunction

endpackage

// File: rtl/ps2_key_tracker_if.sv
// ps2_key_tracker_if: bundles the PS/2 pins and the tracker results.
//   kb_clk, kb_data      : PS/2 lines (driven by the keyboard / master side)
//   key_held[NUM_KEYS]   : level per tracked key
//   key_press[NUM_KEYS]  : one-cycle pulse on the first make of a key
//   byte_valid/byte_data : received byte strobe and last good byte
//   frame_err            : one-cycle pulse on a dropped frame
//   dbg_state            : frame receiver state, for observation only
// Handshake: byte_valid, frame_err and key_press are single-cycle strobes with
// no back-pressure; the consumer must sample them on the cycle they are high.
// byte_valid and frame_err are mutually exclusive.
interface ps2_key_tracker_if #(
    parameter int NUM_KEYS = 4
);
    logic                  kb_clk;
    logic                  kb_data;
    logic [NUM_KEYS-1:0]   key_held;
    logic [NUM_KEYS-1:0]   key_press;
    logic                  byte_valid;
    logic [7:0]            byte_data;
    logic                  frame_err;
    ps2_pkg::frame_state_e dbg_state;

    modport master (
        output kb_clk, kb_data,
        input  key_held, key_press, byte_valid, byte_data, frame_err, dbg_state
    );

    modport slave (
        input  kb_clk, kb_data,
        output key_held, key_press, byte_valid, byte_data, frame_err, dbg_state
    );
endinterface

// File: rtl/ps2_rx_frame.sv
// ps2_rx_frame: PS/2 serial frame receiver.
//   Synchronises kb_clk/kb_data, debounces the clock with a FILTER_LEN-deep
//   agreement filter, and deframes start/8 data/parity/stop frames.
// Ports:
//   i_clk, i_rst      : system clock, async active-high reset
//   i_kb_clk/i_kb_data: raw asynchronous PS/2 lines
//   o_byte_valid      : one-cycle pulse, good frame received
//   o_byte_data       : last good byte, held until the next one
//   o_frame_err       : one-cycle pulse on stop, parity or timeout error
//   o_state           : current frame state
// Build option: PS2_PARITY_CHECK_EN enables odd-parity checking; otherwise the
// parity bit is sampled and ignored.
module ps2_rx_frame
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_kb_clk,
    input  logic         i_kb_data,
    output logic         o_byte_valid,
    output logic [7:0]   o_byte_data,
    output logic         o_frame_err,
    output frame_state_e o_state
);
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

    logic [1:0]            r_clk_sync;
    logic [1:0]            r_data_sync;
    logic [FILTER_LEN-2:0] r_filt_sh;
    logic                  r_clk_f;
    frame_state_e          r_state;
    logic [7:0]            r_shift;
    logic [2:0]            r_bit_cnt;
    logic [WD_W-1:0]       r_wdog;
    logic                  r_byte_valid;
    logic [7:0]            r_byte_data;
    logic                  r_frame_err;

    logic [FILTER_LEN-1:0] w_window;
    logic                  w_fall;
    logic                  w_din;
    logic                  w_timeout;
    logic                  w_parity_ok;
    frame_state_e          w_state_next;
    logic [7:0]            w_shift_next;
    logic [2:0]            w_cnt_next;
    logic                  w_valid_next;
    logic [7:0]            w_data_next;
    logic                  w_err_next;

    // Current sample plus the FILTER_LEN-1 previous ones; the filtered clock
    // moves only when the whole window agrees, so the newest sample already
    // counts towards the decision (lag = 2 sync + FILTER_LEN).
    assign w_window  = {r_filt_sh, r_clk_sync[1]};
    assign w_fall    = r_clk_f && (w_window == '0);
    assign w_din     = r_data_sync[1];
    assign w_timeout = (r_wdog == WD_W'(TIMEOUT_CYC));

`ifdef PS2_PARITY_CHECK_EN
    logic r_parity;
    logic w_parity_next;
    // Odd parity: data bits plus parity bit hold an odd number of ones.
    assign w_parity_ok = ^{r_shift, r_parity};
`else
    assign w_parity_ok = 1'b1;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            // Line idles high: start all conditioning at 1 so no false fall.
            r_clk_sync  <= 2'b11;
            r_data_sync <= 2'b11;
            r_filt_sh   <= '1;
            r_clk_f     <= 1'b1;
        end else begin
            r_clk_sync  <= {r_clk_sync[0], i_kb_clk};
            r_data_sync <= {r_data_sync[0], i_kb_data};
            r_filt_sh   <= w_window[FILTER_LEN-2:0];
            if (w_window == '1) begin
                r_clk_f <= 1'b1;
            end else if (w_window == '0) begin
                r_clk_f <= 1'b0;
            end
        end
    end

    // Watchdog: cycles since the last fall while a frame is open. A fall in
    // the same cycle as expiry wins because it clears the count and the
    // next-state logic gives it priority.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wdog <= '0;
        end else if (r_state == ST_IDLE || w_fall) begin
            r_wdog <= '0;
        end else if (!w_timeout) begin
            r_wdog <= r_wdog + 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= ST_IDLE;
            r_shift      <= '0;
            r_bit_cnt    <= '0;
            r_byte_valid <= 1'b0;
            r_byte_data  <= '0;
            r_frame_err  <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_shift      <= w_shift_next;
            r_bit_cnt    <= w_cnt_next;
            r_byte_valid <= w_valid_next;
            r_byte_data  <= w_data_next;
            r_frame_err  <= w_err_next;
        end
    end

`ifdef PS2_PARITY_CHECK_EN
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_parity <= 1'b0;
        end else begin
            r_parity <= w_parity_next;
        end
    end
`endif

    always_comb begin
        w_state_next = r_state;
        w_shift_next = r_shift;
        w_cnt_next   = r_bit_cnt;
        w_valid_next = 1'b0;
        w_data_next  = r_byte_data;
        w_err_next   = 1'b0;
`ifdef PS2_PARITY_CHECK_EN
        w_parity_next = r_parity;
`endif
        if (w_fall) begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_din) begin
                        w_state_next = ST_DATA;
                        w_cnt_next   = '0;
                    end
                end
                ST_DATA: begin
                    w_shift_next = {w_din, r_shift[7:1]};  // LSB first
                    w_cnt_next   = r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7) begin
                        w_state_next = ST_PARITY;
                    end
                end
                ST_PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
                    w_parity_next = w_din;
`endif
                    w_state_next = ST_STOP;
                end
                ST_STOP: begin
                    w_state_next = ST_IDLE;
                    if (w_din && w_parity_ok) begin
                        w_valid_next = 1'b1;
                        w_data_next  = r_shift;
                    end else begin
                        w_err_next = 1'b1;
                    end
                end
                default: w_state_next = ST_IDLE;
            endcase
        end else if (r_state != ST_IDLE && w_timeout) begin
            w_state_next = ST_IDLE;
            w_err_next   = 1'b1;
        end
    end

    assign o_byte_valid = r_byte_valid;
    assign o_byte_data  = r_byte_data;
    assign o_frame_err  = r_frame_err;
    assign o_state      = r_state;

endmodule

// File: rtl/ps2_key_tracker.sv
// ps2_key_tracker: PS/2 keyboard front end with a configurable key table.
//   Receives frames via ps2_rx_frame, tracks E0 (extended) and F0 (break)
//   prefixes, and keeps a held level per table entry.
// Ports:
//   clk_50MHz : system clock
//   reset     : async active-high reset
//   bus       : ps2_key_tracker_if slave (PS/2 pins in, key/byte results out)
// Parameters: NUM_KEYS (1..16), KEY_CODES (9 bits per key, bit 8 = E0),
//   FILTER_LEN, TIMEOUT_CYC.
// Build option: PS2_PARITY_CHECK_EN (odd-parity check in the receiver).
module ps2_key_tracker
    import ps2_pkg::*;
#(
    parameter int                       NUM_KEYS    = 4,
    parameter logic [9*NUM_KEYS-1:0]    KEY_CODES   = {9'h172, 9'h175, 9'h01B, 9'h01C},
    parameter int                       FILTER_LEN  = 8,
    parameter int                       TIMEOUT_CYC = 100000
) (
    input  logic              clk_50MHz,
    input  logic              reset,
    ps2_key_tracker_if.slave  bus
);
    logic                w_byte_valid;
    logic [7:0]          w_byte_data;
    logic                w_frame_err;
    frame_state_e        w_state;
    logic [8:0]          w_code;
    logic [NUM_KEYS-1:0] w_match;

    logic                r_ext;
    logic                r_brk;
    logic [NUM_KEYS-1:0] r_key_held;
    logic [NUM_KEYS-1:0] r_key_press;

    ps2_rx_frame #(
        .FILTER_LEN  (FILTER_LEN),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_rx (
        .i_clk        (clk_50MHz),
        .i_rst        (reset),
        .i_kb_clk     (bus.kb_clk),
        .i_kb_data    (bus.kb_data),
        .o_byte_valid (w_byte_valid),
        .o_byte_data  (w_byte_data),
        .o_frame_err  (w_frame_err),
        .o_state      (w_state)
    );

    // Every table entry is compared in parallel; duplicates all match.
    always_comb begin
        w_code  = pack_code(r_ext, w_byte_data);
        w_match = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            w_match[i] = (KEY_CODES[9*i +: 9] == w_code);
        end
    end

    always_ff @(posedge clk_50MHz or posedge reset) begin
        if (reset) begin
            r_ext       <= 1'b0;
            r_brk       <= 1'b0;
            r_key_held  <= '0;
            r_key_press <= '0;
        end else begin
            r_key_press <= '0;
            if (w_byte_valid) begin
                if (w_byte_data == PS2_EXT) begin
                    r_ext <= 1'b1;
                end else if (w_byte_data == PS2_BREAK) begin
                    r_brk <= 1'b1;
                end else begin
                    for (int i = 0; i < NUM_KEYS; i++) begin
                        if (w_match[i]) begin
                            if (r_brk) begin
                                r_key_held[i] <= 1'b0;
                            end else begin
                                r_key_held[i]  <= 1'b1;
                                // Typematic repeats arrive while held: no pulse.
                                r_key_press[i] <= ~r_key_held[i];
                            end
                        end
                    end
                    // Any complete code, matched or not, ends the prefix sequence.
                    r_ext <= 1'b0;
                    r_brk <= 1'b0;
                end
            end
        end
    end

    assign bus.key_held   = r_key_held;
    assign bus.key_press  = r_key_press;
    assign bus.byte_valid = w_byte_valid;
    assign bus.byte_data  = w_byte_data;
    assign bus.frame_err  = w_frame_err;
    assign bus.dbg_state  = w_state;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// tb_ps2_key_tracker: directed bench for ps2_key_tracker.
// PS/2 clock is scaled to 80 system cycles per bit and TIMEOUT_CYC to 3000 to
// keep the run short; the filter depth stays at its default of 8.
module tb_ps2_key_tracker;
    import ps2_pkg::*;

    localparam int HALF       = 40;
    localparam int TB_TIMEOUT = 3000;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_checks = 0;
    int n_errors = 0;

    logic [8:0] exp_q[$];          // bit 8 = frame_err event, else byte_data
    logic [3:0] exp_held = 4'b0000;
    int         exp_press [4] = '{0, 0, 0, 0};
    int         press_cnt [4] = '{0, 0, 0, 0};

    ps2_key_tracker_if #(.NUM_KEYS(4)) bus ();

    ps2_key_tracker #(
        .NUM_KEYS    (4),
        .FILTER_LEN  (8),
        .TIMEOUT_CYC (TB_TIMEOUT)
    ) dut (
        .clk_50MHz (clk),
        .reset     (rst),
        .bus       (bus)
    );

    // Clock / safety net
    always #10 clk = ~clk;

    initial begin
        repeat (150000) @(posedge clk);
        $display("FAIL global_timeout: got no end of test, expected finish");
        $fatal(1, "bench stalled");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_keys(input string name);
        check({name, "_held"}, 32'(bus.key_held), 32'(exp_held));
        for (int i = 0; i < 4; i++) begin
            check($sformatf("%s_press%0d", name, i), press_cnt[i], exp_press[i]);
        end
    endtask

    // Drivers
    task automatic drive_bit(input logic b);
        bus.kb_data = b;
        repeat (HALF) @(negedge clk);
        bus.kb_clk = 1'b0;
        repeat (HALF) @(negedge clk);
        bus.kb_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic bad_par,
                              input logic stop, input int nbits);
        logic [10:0] f;
        f = {stop, (~^d) ^ bad_par, d, 1'b0};
        for (int i = 0; i < nbits; i++) drive_bit(f[i]);
        bus.kb_data = 1'b1;
        repeat (2 * HALF) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] d);
        exp_q.push_back({1'b0, d});
        send_frame(d, 1'b0, 1'b1, 11);
    endtask

    task automatic wait_drain(input string name, input int max_cyc);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        check(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        logic [8:0] exp_ev;
        logic [8:0] act_ev;
        if (!rst) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.key_press[i]) press_cnt[i]++;
            end
            if (bus.byte_valid || bus.frame_err) begin
                check("valid_err_exclusive", 32'(bus.byte_valid & bus.frame_err), 32'd0);
                act_ev = bus.frame_err ? 9'h100 : {1'b0, bus.byte_data};
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_event: got 0x%03h, expected no event", act_ev);
                end else begin
                    exp_ev = exp_q.pop_front();
                    check("rx_event", 32'(act_ev), 32'(exp_ev));
                end
            end
        end
    end

    // Stimulus
    initial begin
        bus.kb_clk  = 1'b1;
        bus.kb_data = 1'b1;
        rst = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_key_held", 32'(bus.key_held), 32'd0);
        check("rst_key_press", 32'(bus.key_press), 32'd0);
        check("rst_byte_valid", 32'(bus.byte_valid), 32'd0);
        check("rst_byte_data", 32'(bus.byte_data), 32'd0);
        check("rst_frame_err", 32'(bus.frame_err), 32'd0);
        check("rst_state", 32'(bus.dbg_state), 32'(ST_IDLE));

        // Press / repeat / release A
        send_byte(8'h1C);
        exp_held = 4'b0001; exp_press[0] = 1;
        check_keys("press_a");
        send_byte(8'h1C);
        check_keys("repeat_a");
        send_byte(PS2_BREAK); send_byte(8'h1C);
        exp_held = 4'b0000;
        check_keys("release_a");
        send_byte(8'h1C);
        exp_held = 4'b0001; exp_press[0] = 2;
        check_keys("press_a_again");
        send_byte(PS2_BREAK); send_byte(8'h1C);
        exp_held = 4'b0000;
        check_keys("release_a_again");

        // Extended keys
        send_byte(PS2_EXT); send_byte(8'h75);
        exp_held = 4'b0100; exp_press[2] = 1;
        check_keys("press_up");
        send_byte(8'h75);
        check_keys("plain_75");
        send_byte(PS2_EXT); send_byte(8'h72);
        exp_held = 4'b1100; exp_press[3] = 1;
        send_byte(8'h1B);
        exp_held = 4'b1110; exp_press[1] = 1;
        check_keys("multi_held");
        send_byte(PS2_EXT); send_byte(PS2_BREAK); send_byte(8'h75);
        exp_held = 4'b1010;
        check_keys("release_up");
        send_byte(PS2_BREAK); send_byte(8'h1B);
        send_byte(PS2_EXT); send_byte(PS2_BREAK); send_byte(8'h72);
        exp_held = 4'b0000;
        check_keys("release_all");

        // Frame errors
`ifdef PS2_PARITY_CHECK_EN
        exp_q.push_back(9'h100);
        send_frame(8'h1C, 1'b1, 1'b1, 11);
        check_keys("parity_err");
`else
        exp_q.push_back({1'b0, 8'h1C});
        send_frame(8'h1C, 1'b1, 1'b1, 11);
        exp_held = 4'b0001; exp_press[0] = 3;
        check_keys("parity_ignored");
        send_byte(PS2_BREAK); send_byte(8'h1C);
        exp_held = 4'b0000;
        check_keys("parity_ignored_rel");
`endif
        exp_q.push_back(9'h100);
        send_frame(8'h1C, 1'b0, 1'b0, 11);
        check_keys("stop_err");

        // Timeout after start + 4 data bits
        exp_q.push_back(9'h100);
        send_frame(8'h1B, 1'b0, 1'b1, 5);
        wait_drain("timeout_err", TB_TIMEOUT + 500);
        check("timeout_state", 32'(bus.dbg_state), 32'(ST_IDLE));
        send_byte(8'h1B);
        exp_held = 4'b0010; exp_press[1] = 2;
        check_keys("after_timeout");

        // 5-cycle clock glitch with data low must not start a frame
        bus.kb_data = 1'b0;
        repeat (10) @(negedge clk);
        bus.kb_clk = 1'b0;
        repeat (5) @(negedge clk);
        bus.kb_clk = 1'b1;
        repeat (10) @(negedge clk);
        bus.kb_data = 1'b1;
        repeat (20) @(negedge clk);
        check("glitch_state", 32'(bus.dbg_state), 32'(ST_IDLE));

        // Reset in the middle of a frame
        send_frame(8'h1B, 1'b0, 1'b1, 5);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        exp_held = 4'b0000;
        check("midrst_held", 32'(bus.key_held), 32'(exp_held));
        check("midrst_byte_data", 32'(bus.byte_data), 32'd0);
        check("midrst_state", 32'(bus.dbg_state), 32'(ST_IDLE));
        send_byte(8'h1B);
        exp_held = 4'b0010; exp_press[1] = 3;
        check_keys("after_reset");

        repeat (200) @(negedge clk);
        wait_drain("scoreboard_drained", 10);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
